// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak rho offsets, lane/pi index helpers and FSM state type
package keccak_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} rhopi_state_e;

    // Lane 0 sits in the least significant byte; lane order is 5x+y.
    localparam logic [25*8-1:0] RHO_OFFSETS = {
        8'd14, 8'd8,  8'd39, 8'd20, 8'd27,
        8'd56, 8'd21, 8'd25, 8'd55, 8'd28,
        8'd61, 8'd15, 8'd43, 8'd6,  8'd62,
        8'd2,  8'd45, 8'd10, 8'd44, 8'd1,
        8'd18, 8'd41, 8'd3,  8'd36, 8'd0
    };

    function automatic logic [7:0] rho_off(input int k);
        return RHO_OFFSETS[k*8 +: 8];
    endfunction

    function automatic int lane_idx(input int x, input int y, input int w);
        return (5*x + y) * w;
    endfunction

    function automatic int pi_dst(input int x, input int y);
        return 5*y + (2*x + 3*y) % 5;
    endfunction

endpackage

// File: rtl/keccak_lane_rot.sv
// rtl/keccak_lane_rot.sv - single-lane W-bit rotator, left or right by 0..W-1
module keccak_lane_rot #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic [W-1:0]  lane_in,
    input  logic [AW-1:0] amt,
    input  logic          left,
    output logic [W-1:0]  lane_out
);

    logic [AW-1:0] idx;

    // W is a power of two, so AW-bit index arithmetic wraps exactly mod W.
    always_comb begin
        lane_out = '0;
        idx      = '0;
        for (int i = 0; i < W; i++) begin
            idx         = left ? (AW'(i) - amt) : (AW'(i) + amt);
            lane_out[i] = lane_in[idx];
        end
    end

endmodule

// File: rtl/keccak_rhopi_inv_serial.sv
// rtl/keccak_rhopi_inv_serial.sv - lane-serial inverse rho+pi; KECCAK_RHOPI_FWD_EN adds fwd port for forward rho-pi
module keccak_rhopi_inv_serial
    import keccak_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [25*W-1:0] in_state,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [25*W-1:0] out_state
`ifdef KECCAK_RHOPI_FWD_EN
    ,
    input  logic           fwd
`endif
);

    localparam int AW = (W > 1) ? $clog2(W) : 1;
    localparam int IW = $clog2(25*W);

    rhopi_state_e   state_q, state_d;
    logic [4:0]     k_q;
    logic [25*W-1:0] src_q, dst_q;
    logic           fwd_q;

    int             kx, ky;
    logic [AW-1:0]  rot_amt;
    logic [IW-1:0]  rd_base, wr_base;
    logic [W-1:0]   lane_rd, lane_rot;

    // Inverse walks destination lanes (reading the pi source); forward walks
    // source lanes (writing the pi destination). Both take 25 cycles.
    always_comb begin
        kx      = int'(k_q) / 5;
        ky      = int'(k_q) % 5;
        rot_amt = AW'(int'(rho_off(int'(k_q))) % W);
        if (fwd_q) begin
            rd_base = IW'(lane_idx(kx, ky, W));
            wr_base = IW'(pi_dst(kx, ky) * W);
        end else begin
            rd_base = IW'(pi_dst(kx, ky) * W);
            wr_base = IW'(lane_idx(kx, ky, W));
        end
    end

    assign lane_rd = src_q[rd_base +: W];

    keccak_lane_rot #(.W(W), .AW(AW)) u_rot (
        .lane_in  (lane_rd),
        .amt      (rot_amt),
        .left     (fwd_q),
        .lane_out (lane_rot)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (k_q == 5'd24) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        src_q <= in_state;
                        dst_q <= '0;
                        k_q   <= '0;
                    end
                end
                RUN: begin
                    dst_q[wr_base +: W] <= lane_rot;
                    if (k_q != 5'd24) k_q <= k_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef KECCAK_RHOPI_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            fwd_q <= fwd;
        end
    end
`else
    assign fwd_q = 1'b0;
`endif

    assign out_state = dst_q;

endmodule

// File: tb/tb_keccak_rhopi_inv_serial.sv
// tb/tb_keccak_rhopi_inv_serial.sv - scoreboard bench for keccak_rhopi_inv_serial
module tb_keccak_rhopi_inv_serial;

    localparam int W   = 8;
    localparam int N   = 25*W;
    localparam int LAT = 26;
    localparam int RHO [25] = '{0, 36, 3, 41, 18, 1, 44, 10, 45, 2, 62, 6, 43, 15, 61,
                                28, 55, 25, 21, 56, 27, 20, 39, 8, 14};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_state;
    logic         fwd_i = 1'b0;

    logic [N-1:0] sb [$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keccak_rhopi_inv_serial #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
`ifdef KECCAK_RHOPI_FWD_EN
        ,
        .fwd       (fwd_i)
`endif
    );

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[(i + n) % W];
        return r;
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[(i + n) % W] = v[i];
        return r;
    endfunction

    function automatic logic [N-1:0] model_inv(input logic [N-1:0] s);
        logic [N-1:0] o;
        o = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                o[(5*x+y)*W +: W] = rotr(s[(5*y + (2*x+3*y)%5)*W +: W], RHO[5*x+y] % W);
        return o;
    endfunction

    function automatic logic [N-1:0] model_fwd(input logic [N-1:0] s);
        logic [N-1:0] o;
        o = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                o[(5*y + (2*x+3*y)%5)*W +: W] = rotl(s[(5*x+y)*W +: W], RHO[5*x+y] % W);
        return o;
    endfunction

    function automatic logic [N-1:0] rand_state();
        logic [N-1:0] s;
        for (int i = 0; i < 25; i++) s[i*W +: W] = W'($urandom);
        return s;
    endfunction

    task automatic accept_state(input logic [N-1:0] st, input logic f);
        @(negedge clk);
        in_state = st;
        in_valid = 1'b1;
        fwd_i    = f;
        sb.push_back(f ? model_fwd(st) : model_inv(st));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = rand_state();
        fwd_i    = ~f;
    endtask

    // Cycles counted with the accepting edge as cycle 1; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) return;
            @(posedge clk);
            lat++;
        end
        lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++;
        if (out_state !== '0) begin n_err++; $display("FAIL reset_out_state got %h want 0", out_state); end
        rst_n     = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_single(input string name, input logic [N-1:0] st, input int lane, input logic [W-1:0] lane_val);
        int lat;
        logic [N-1:0] exp, masked;
        accept_state(st, 1'b0);
        wait_valid(lat);
        n_vec++;
        if (lat !== LAT) begin n_err++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT); end
        exp = sb.size() > 0 ? sb.pop_front() : '1;
        n_vec++;
        if (out_state !== exp) begin n_err++; $display("FAIL %s_state got %h want %h", name, out_state, exp); end
        n_vec++;
        if (out_state[lane*W +: W] !== lane_val) begin
            n_err++; $display("FAIL %s_lane%0d got %h want %h", name, lane, out_state[lane*W +: W], lane_val);
        end
        masked = out_state;
        masked[lane*W +: W] = '0;
        n_vec++;
        if (masked !== '0) begin n_err++; $display("FAIL %s_other_lanes got %h want 0", name, masked); end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_release got valid=%b ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [N-1:0] exp;
        for (int t = 0; t < 6; t++) begin
            accept_state(rand_state(), 1'b0);
            wait_valid(lat);
            n_vec++;
            if (lat !== LAT) begin n_err++; $display("FAIL random%0d_latency got %0d want %0d", t, lat, LAT); end
            exp = sb.size() > 0 ? sb.pop_front() : '1;
            n_vec++;
            if (out_state !== exp) begin n_err++; $display("FAIL random%0d_state got %h want %h", t, out_state, exp); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [N-1:0] held, exp;
        out_ready = 1'b0;
        accept_state(rand_state(), 1'b0);
        wait_valid(lat);
        held = out_state;
        exp = sb.size() > 0 ? sb.pop_front() : '1;
        n_vec++;
        if (held !== exp) begin n_err++; $display("FAIL bp_state got %h want %h", held, exp); end
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_state = rand_state();
            @(negedge clk);
            n_vec++;
            if (out_state !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d got valid=%b ready=%b state=%h want 1/0 %h", c, out_valid, in_ready, out_state, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [N-1:0] exp;
        accept_state(rand_state(), 1'b0);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== '0) begin
            n_err++; $display("FAIL midrun_reset got valid=%b ready=%b state=%h want 0/1/0", out_valid, in_ready, out_state);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        accept_state(rand_state(), 1'b0);
        wait_valid(lat);
        n_vec++;
        if (lat !== LAT) begin n_err++; $display("FAIL midrun_fresh_latency got %0d want %0d", lat, LAT); end
        exp = sb.size() > 0 ? sb.pop_front() : '1;
        n_vec++;
        if (out_state !== exp) begin n_err++; $display("FAIL midrun_fresh_state got %h want %h", out_state, exp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [N-1:0] exp, st_b;
        accept_state(rand_state(), 1'b0);
        wait_valid(lat);
        exp = sb.size() > 0 ? sb.pop_front() : '1;
        n_vec++;
        if (out_state !== exp) begin n_err++; $display("FAIL b2b_first got %h want %h", out_state, exp); end
        st_b     = rand_state();
        in_state = st_b;
        in_valid = 1'b1;
        sb.push_back(model_inv(st_b));
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = '0;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept got ready=%b want 0", in_ready); end
        wait_valid(lat);
        n_vec++;
        if (lat !== LAT) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        exp = sb.size() > 0 ? sb.pop_front() : '1;
        n_vec++;
        if (out_state !== exp) begin n_err++; $display("FAIL b2b_second got %h want %h", out_state, exp); end
        @(posedge clk);
        #1;
    endtask

`ifdef KECCAK_RHOPI_FWD_EN
    task automatic test_fwd_roundtrip();
        int lat;
        logic [N-1:0] st, mid, exp;
        for (int t = 0; t < 3; t++) begin
            st = rand_state();
            accept_state(st, 1'b1);
            wait_valid(lat);
            exp = sb.size() > 0 ? sb.pop_front() : '1;
            n_vec++;
            if (out_state !== exp || lat !== LAT) begin
                n_err++; $display("FAIL fwd%0d got %h lat=%0d want %h lat=%0d", t, out_state, lat, exp, LAT);
            end
            mid = out_state;
            @(posedge clk);
            #1;
            accept_state(mid, 1'b0);
            wait_valid(lat);
            if (sb.size() > 0) void'(sb.pop_front());
            n_vec++;
            if (out_state !== st) begin n_err++; $display("FAIL roundtrip%0d got %h want %h", t, out_state, st); end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        logic [N-1:0] st;
        test_reset();
        st = '0; st[0*W +: W] = 8'hA5;
        test_single("lane0", st, 0, 8'hA5);
        st = '0; st[2*W +: W] = 8'h02;
        test_single("lane2", st, 5, 8'h01);
        st = '0; st[20*W +: W] = 8'h40;
        test_single("lane20", st, 24, 8'h01);
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef KECCAK_RHOPI_FWD_EN
        test_fwd_roundtrip();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
